rst_seq: RTL and testbench

Parametrised reset synchroniser and sequencer for the npc core. Takes the board-level asynchronous active-low reset, asserts all downstream resets asynchronously, de-asserts them synchronously through a configurable synchroniser chain, and then releases up to NUM_CH reset domains one after another with programmable gaps. It also supports a synchronous software-triggered reset re-sequence. It sits at the top of the design and feeds per-domain resets (core, memory, peripherals, debug).

---
 rtl/rst_seq.sv | 129 ++++++++++++
 tb/tb_rst_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: reset synchroniser plus sequenced, gap-programmable release of NUM_CH reset domains.
// Define RST_SEQ_SW_RST_EN to enable the sw_rst_req re-sequence; otherwise the port is ignored.
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int DLY_W       = 8,
    parameter int STRETCH     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sw_rst_req,
    input  logic [NUM_CH*DLY_W-1:0] ch_dly,
    output logic [NUM_CH-1:0]       o_rst_n_sync,
    output logic                    o_busy,
    output logic                    o_all_released
);
    localparam int CNT_W = $clog2(STRETCH + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {ASSERT, RELEASE, DONE} state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0]        sync_q;
    logic                          rst_sync;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [DLY_W-1:0]              rcnt_q, rcnt_d, dly_next;
    logic [NUM_CH-1:0][DLY_W-1:0]  dly_q, dly_d;
    logic [NUM_CH-1:0]             rst_q, rst_d;
    logic                          busy_q, busy_d, all_q, all_d;
    logic                          sw_hit;

    assign rst_sync = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_SW_RST_EN
    // Software request only re-sequences once the stretch phase is over.
    assign sw_hit = sw_rst_req && (state_q != ASSERT);
`else
    logic sw_unused;
    assign sw_unused = sw_rst_req;
    assign sw_hit    = 1'b0;
`endif

    // Gap for the channel after idx_q, taken from the snapshot.
    always_comb begin
        dly_next = '0;
        for (int i = 1; i < NUM_CH; i++)
            if (idx_q == IDX_W'(i - 1)) dly_next = dly_q[i];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rcnt_d  = rcnt_q;
        dly_d   = dly_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        all_d   = all_q;
        case (state_q)
            ASSERT: begin
                if (rst_sync) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = RELEASE;
                        idx_d   = '0;
                        dly_d   = ch_dly;
                        rcnt_d  = ch_dly[DLY_W-1:0];
                    end
                end
            end
            RELEASE: begin
                if (rcnt_q != '0) begin
                    rcnt_d = rcnt_q - 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CH; i++)
                        if (idx_q == IDX_W'(i)) rst_d[i] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        all_d   = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        rcnt_d = dly_next;
                    end
                end
            end
            DONE:    ;
            default: state_d = ASSERT;
        endcase
        if (sw_hit) begin
            state_d = ASSERT;
            cnt_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
            all_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rcnt_q  <= '0;
            dly_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            all_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
            dly_q   <= dly_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            all_q   <= all_d;
        end
    end

    assign o_rst_n_sync   = rst_q;
    assign o_busy         = busy_q;
    assign o_all_released = all_q;
endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: table of delay vectors with hand-derived release edges, scoreboard per edge,
// plus async-abort, rst_n glitch and software-reset sequences.
module tb_rst_seq;
    localparam int S  = 2;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ST = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sw_rst_req = 1'b0;
    logic [N*W-1:0] ch_dly = '0;
    logic [N-1:0]   o_rst_n_sync;
    logic           o_busy, o_all_released;

    int n_cmp = 0;
    int n_err = 0;

    rst_seq #(.SYNC_STAGES(S), .NUM_CH(N), .DLY_W(W), .STRETCH(ST)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_rst_req     (sw_rst_req),
        .ch_dly         (ch_dly),
        .o_rst_n_sync   (o_rst_n_sync),
        .o_busy         (o_busy),
        .o_all_released (o_all_released)
    );

    always #5 clk = ~clk;

    // rel[i]: edge number at which channel i is expected to release
    typedef struct packed {
        logic [N*W-1:0]     dly;
        logic [N-1:0][15:0] rel;
        int                 chg;
        int                 abort;
    } vec_t;

    typedef struct packed {
        int         k;
        logic [5:0] want;
    } sb_t;

    vec_t tbl[6];
    sb_t  q[$];

    localparam logic [5:0] RST_ALL  = 6'b0000_1_0;
    localparam logic [5:0] DONE_ALL = 6'b1111_0_1;

    function automatic logic [5:0] dut_out();
        return {o_rst_n_sync, o_busy, o_all_released};
    endfunction

    function automatic logic [5:0] want_at(int k, logic [N-1:0][15:0] rel);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (k >= int'(rel[i]));
        return {r, ~r[N-1], r[N-1]};
    endfunction

    function automatic logic [N-1:0][15:0] rel_of(int lead, logic [N*W-1:0] d);
        logic [N-1:0][15:0] r;
        int t;
        t = lead + ST;
        for (int i = 0; i < N; i++) begin
            t += int'(d[i*W +: W]) + 1;
            r[i] = 16'(t);
        end
        return r;
    endfunction

    task automatic check(string name, logic [5:0] act, logic [5:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got {rst,busy,all}=%b expected %b", name, act, want);
        end
    endtask

    task automatic run_from_release(vec_t v, string name);
        int  last;
        sb_t s;
        last = (v.abort != 0) ? v.abort : int'(v.rel[N-1]) + 2;
        for (int k = 1; k <= last; k++) q.push_back('{k: k, want: want_at(k, v.rel)});
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (v.chg == k) ch_dly = ~v.dly;
            s = q.pop_front();
            check($sformatf("%s edge%0d", name, s.k), dut_out(), s.want);
        end
        if (v.abort != 0) begin
            #2 rst_n = 1'b0;
            #1 check($sformatf("%s async_assert", name), dut_out(), RST_ALL);
        end
    endtask

    task automatic run(vec_t v, string name);
        @(negedge clk);
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        ch_dly     = v.dly;
        @(negedge clk);
        check($sformatf("%s reset_state", name), dut_out(), RST_ALL);
        @(negedge clk);
        rst_n = 1'b1;
        run_from_release(v, name);
    endtask

    initial begin
        logic [N-1:0][15:0] rel;
        sb_t                s;

        tbl[0] = '{dly: 32'h00_00_00_00, rel: {16'd10, 16'd9,  16'd8,  16'd7},  chg: 0,  abort: 0};
        tbl[1] = '{dly: 32'h03_00_05_02, rel: {16'd20, 16'd16, 16'd15, 16'd9},  chg: 10, abort: 0};
        tbl[2] = '{dly: 32'h01_01_01_01, rel: {16'd14, 16'd12, 16'd10, 16'd8},  chg: 0,  abort: 0};
        tbl[3] = '{dly: 32'h07_00_03_00, rel: {16'd20, 16'd12, 16'd11, 16'd7},  chg: 0,  abort: 0};
        tbl[4] = '{dly: 32'h00_00_00_0A, rel: {16'd20, 16'd19, 16'd18, 16'd17}, chg: 0,  abort: 0};
        tbl[5] = '{dly: 32'h03_00_05_02, rel: {16'd20, 16'd16, 16'd15, 16'd9},  chg: 0,  abort: 15};

        for (int i = 0; i < 6; i++) run(tbl[i], $sformatf("vec%0d", i));
        run(tbl[1], "after_abort");

        // one-cycle rst_n glitch while DONE
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("glitch assert", dut_out(), RST_ALL);
        ch_dly = tbl[0].dly;
        @(negedge clk);
        check("glitch held", dut_out(), RST_ALL);
        rst_n = 1'b1;
        run_from_release(tbl[0], "glitch");

`ifdef RST_SEQ_SW_RST_EN
        run(tbl[2], "pre_sw");
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1 sw_rst_req = 1'b0;
        check("sw edge0", dut_out(), RST_ALL);
        rel = rel_of(0, tbl[2].dly);
        for (int k = 1; k <= int'(rel[N-1]) + 2; k++) q.push_back('{k: k, want: want_at(k, rel)});
        for (int k = 1; k <= int'(rel[N-1]) + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) sw_rst_req = 1'b1;
            if (k == 2) sw_rst_req = 1'b0;
            s = q.pop_front();
            check($sformatf("sw edge%0d", s.k), dut_out(), s.want);
        end
`else
        sw_rst_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 check($sformatf("sw_ignored edge%0d", k), dut_out(), DONE_ALL);
        end
        sw_rst_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
